// File: rtl/divider_sequencer_pkg.sv
// Shared types and constants for the divider sequencer and its bench.
package divider_sequencer_pkg;

    // Width of the external loadable counter and of the period tally.
    localparam int CNT_W  = 8;
    localparam int PCNT_W = 16;

    // Counter value that ends a period, and the preset used after reset.
    localparam logic [CNT_W-1:0] DEF_TERMINAL = 8'hFF;
    localparam logic [CNT_W-1:0] DEF_PRESET   = 8'h8F;

    // Sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } seq_state_t;

endpackage

// File: rtl/divider_sequencer_sat_counter16.sv
// Saturating tally of completed periods; sticks at all-ones instead of wrapping.
module sat_counter16
    import divider_sequencer_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    output logic [PCNT_W-1:0] count
);

    localparam logic [PCNT_W-1:0] MAX_COUNT = '1;

    logic [PCNT_W-1:0] count_q;

    // Count up on each increment request until the maximum is reached.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (inc && (count_q != MAX_COUNT)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/divider_sequencer.sv
// Sequencer driving an external 8-bit loadable counter as a programmable
// frequency divider. Handshake: a preset transfer happens on any cycle where
// cfg_valid and cfg_ready are both high; cfg_ready is low only in LOAD, and
// cfg_valid may be raised or dropped freely (no hold requirement).
module divider_sequencer
    import divider_sequencer_pkg::*;
#(
    parameter logic [CNT_W-1:0] TERMINAL       = DEF_TERMINAL,
    parameter logic [CNT_W-1:0] DEFAULT_PRESET = DEF_PRESET
) (
    input  logic              clock_oscillator,
    input  logic              pin_name1,
    input  logic              start,
    input  logic              stop,
    input  logic              mode,
    input  logic              cfg_valid,
    input  logic [CNT_W-1:0]  cfg_data,
    output logic              cfg_ready,
    input  logic [CNT_W-1:0]  cnt_q,
    output logic              load_n,
    output logic [CNT_W-1:0]  preset,
    output logic              div_tick,
    output logic              busy,
    output logic [PCNT_W-1:0] period_cnt
);

    seq_state_t       state;
    logic [CNT_W-1:0] shadow;
    logic             transfer;
    logic             term_hit;
    logic             period_done;

    assign transfer    = cfg_valid && cfg_ready;
    // cnt_q only matters in RUN; in LOAD it is still the stale previous value.
    assign term_hit    = (state == ST_RUN) && (cnt_q == TERMINAL);
    // stop wins over terminal detect: an aborted period is not counted.
    assign period_done = term_hit && !stop;

    // FSM with registered outputs; outputs are set together with the state they belong to.
    always_ff @(posedge clock_oscillator) begin
        if (pin_name1) begin
            state     <= ST_IDLE;
            load_n    <= 1'b1;
            preset    <= DEFAULT_PRESET;
            shadow    <= DEFAULT_PRESET;
            div_tick  <= 1'b0;
            busy      <= 1'b0;
            cfg_ready <= 1'b1;
        end else begin
            div_tick <= 1'b0;
            if (transfer) begin
                shadow <= cfg_data;
            end
            case (state)
                ST_IDLE: begin
                    if (start && !stop) begin
                        state     <= ST_LOAD;
                        load_n    <= 1'b0;
                        busy      <= 1'b1;
                        cfg_ready <= 1'b0;
                        // A value accepted this very cycle is used for this load.
                        preset    <= transfer ? cfg_data : shadow;
                    end
                end
                ST_LOAD: begin
                    load_n    <= 1'b1;
                    cfg_ready <= 1'b1;
                    if (stop) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state <= ST_RUN;
                        busy  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        state     <= ST_IDLE;
                        load_n    <= 1'b1;
                        busy      <= 1'b0;
                        cfg_ready <= 1'b1;
                    end else if (term_hit) begin
                        div_tick <= 1'b1;
                        if (mode) begin
                            state     <= ST_IDLE;
                            load_n    <= 1'b1;
                            busy      <= 1'b0;
                            cfg_ready <= 1'b1;
                        end else begin
                            state     <= ST_LOAD;
                            load_n    <= 1'b0;
                            busy      <= 1'b1;
                            cfg_ready <= 1'b0;
                            preset    <= transfer ? cfg_data : shadow;
                        end
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    load_n    <= 1'b1;
                    busy      <= 1'b0;
                    cfg_ready <= 1'b1;
                end
            endcase
        end
    end

    sat_counter16 u_period (
        .clk   (clock_oscillator),
        .rst   (pin_name1),
        .inc   (period_done),
        .count (period_cnt)
    );

endmodule

// File: tb/tb_divider_sequencer.sv
// Bench for divider_sequencer with a behavioural loadable up-counter.
module tb_divider_sequencer;
    import divider_sequencer_pkg::*;

    // ---------------- clock / reset / DUT ----------------
    logic              clk = 1'b0;
    logic              pin_name1 = 1'b1;
    logic              start = 1'b0;
    logic              stop = 1'b0;
    logic              mode = 1'b0;
    logic              cfg_valid = 1'b0;
    logic [CNT_W-1:0]  cfg_data = '0;
    logic              cfg_ready;
    logic [CNT_W-1:0]  cnt_q = '0;
    logic              load_n;
    logic [CNT_W-1:0]  preset;
    logic              div_tick;
    logic              busy;
    logic [PCNT_W-1:0] period_cnt;

    logic [31:0] cyc = '0;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // External 8-bit counter: synchronous active-low load, otherwise counts up.
    always @(posedge clk) begin
        if (!load_n) cnt_q <= preset;
        else         cnt_q <= cnt_q + 8'd1;
    end

    divider_sequencer dut (
        .clock_oscillator (clk),
        .pin_name1        (pin_name1),
        .start            (start),
        .stop             (stop),
        .mode             (mode),
        .cfg_valid        (cfg_valid),
        .cfg_data         (cfg_data),
        .cfg_ready        (cfg_ready),
        .cnt_q            (cnt_q),
        .load_n           (load_n),
        .preset           (preset),
        .div_tick         (div_tick),
        .busy             (busy),
        .period_cnt       (period_cnt)
    );

    // ---------------- scoreboard ----------------
    logic [31:0] exp_tick_q[$];
    logic [15:0] exp_pc_q[$];
    logic [15:0] exp_pc = '0;

    // Expected tick at cycle t; period_cnt model saturates at all-ones.
    function automatic void push_tick(input logic [31:0] t);
        if (exp_pc != 16'hFFFF) exp_pc = exp_pc + 16'd1;
        exp_tick_q.push_back(t);
        exp_pc_q.push_back(exp_pc);
    endfunction

    // Every observed tick must match the next expected tick cycle and tally.
    always @(posedge clk) begin
        logic [31:0] t;
        logic [15:0] p;
        #1;
        if (div_tick !== 1'b0) begin
            checks++;
            if (exp_tick_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_tick: tick at cyc=%0d period_cnt=%h, required no tick", cyc, period_cnt);
            end else begin
                t = exp_tick_q.pop_front();
                p = exp_pc_q.pop_front();
                if (cyc !== t || period_cnt !== p) begin
                    errors++;
                    $display("FAIL tick: cyc=%0d period_cnt=%h, required cyc=%0d period_cnt=%h", cyc, period_cnt, t, p);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        step();
        step();
        checks++; if (load_n !== 1'b1) begin errors++; $display("FAIL rst_load_n: got %b want 1", load_n); end
        checks++; if (preset !== 8'h8F) begin errors++; $display("FAIL rst_preset: got %h want 8f", preset); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
        checks++; if (div_tick !== 1'b0) begin errors++; $display("FAIL rst_tick: got %b want 0", div_tick); end
        checks++; if (period_cnt !== 16'd0) begin errors++; $display("FAIL rst_period_cnt: got %h want 0", period_cnt); end
        pin_name1 = 1'b0;
        step();
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL rst_cfg_ready: got %b want 1", cfg_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_continuous();
        logic [31:0] l;
        mode = 1'b0;
        start = 1'b1;
        step();
        l = cyc;
        start = 1'b0;
        checks++; if (load_n !== 1'b0) begin errors++; $display("FAIL cont_load_low: got %b want 0", load_n); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL cont_busy: got %b want 1", busy); end
        checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL cont_ready_in_load: got %b want 0", cfg_ready); end
        checks++; if (preset !== 8'h8F) begin errors++; $display("FAIL cont_preset: got %h want 8f", preset); end
        push_tick(l + 114);
        push_tick(l + 228);
        push_tick(l + 342);
        step();
        checks++; if (load_n !== 1'b1) begin errors++; $display("FAIL cont_load_one_cycle: got %b want 1", load_n); end
        for (int i = 0; i < 400 && exp_tick_q.size() != 0; i++) step();
        checks++; if (exp_tick_q.size() != 0) begin errors++; $display("FAIL cont_timeout: %0d ticks missing, want 0", exp_tick_q.size()); end
        checks++; if (period_cnt !== 16'd3) begin errors++; $display("FAIL cont_period_cnt: got %h want 3", period_cnt); end
        stop = 1'b1;
        step();
        stop = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cont_stop_busy: got %b want 0", busy); end
        exp_tick_q.delete();
        exp_pc_q.delete();
    endtask

    task automatic test_cfg_midrun();
        logic [31:0] l;
        mode = 1'b0;
        start = 1'b1;
        step();
        l = cyc;
        start = 1'b0;
        push_tick(l + 114);
        repeat (20) step();
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL cfg_ready_run: got %b want 1", cfg_ready); end
        cfg_valid = 1'b1;
        cfg_data = 8'hF0;
        step();
        cfg_valid = 1'b0;
        checks++; if (preset !== 8'h8F) begin errors++; $display("FAIL cfg_preset_held: got %h want 8f", preset); end
        push_tick(l + 131);
        push_tick(l + 148);
        for (int i = 0; i < 200 && exp_tick_q.size() > 2; i++) step();
        checks++; if (preset !== 8'hF0) begin errors++; $display("FAIL cfg_preset_applied: got %h want f0", preset); end
        for (int i = 0; i < 100 && exp_tick_q.size() != 0; i++) step();
        checks++; if (exp_tick_q.size() != 0) begin errors++; $display("FAIL cfg_timeout: %0d ticks missing, want 0", exp_tick_q.size()); end
        stop = 1'b1;
        step();
        stop = 1'b0;
        exp_tick_q.delete();
        exp_pc_q.delete();
    endtask

    task automatic test_one_shot();
        logic [31:0] l;
        mode = 1'b1;
        start = 1'b1;
        cfg_valid = 1'b1;
        cfg_data = 8'hFE;
        step();
        l = cyc;
        start = 1'b0;
        cfg_valid = 1'b0;
        checks++; if (preset !== 8'hFE) begin errors++; $display("FAIL os_preset: got %h want fe", preset); end
        push_tick(l + 3);
        repeat (3) step();
        checks++; if (exp_tick_q.size() != 0) begin errors++; $display("FAIL os_tick_missing: %0d pending, want 0", exp_tick_q.size()); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL os_busy: got %b want 0", busy); end
        checks++; if (load_n !== 1'b1) begin errors++; $display("FAIL os_load_n: got %b want 1", load_n); end
        repeat (4) step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL os_stay_idle: got %b want 0", busy); end
        mode = 1'b0;
        exp_tick_q.delete();
        exp_pc_q.delete();
    endtask

    task automatic test_stop_at_terminal();
        mode = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        checks++; if (cnt_q !== 8'hFF) begin errors++; $display("FAIL stop_cnt_setup: got %h want ff", cnt_q); end
        stop = 1'b1;
        step();
        stop = 1'b0;
        checks++; if (div_tick !== 1'b0) begin errors++; $display("FAIL stop_tick: got %b want 0", div_tick); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stop_busy: got %b want 0", busy); end
        checks++; if (load_n !== 1'b1) begin errors++; $display("FAIL stop_load_n: got %b want 1", load_n); end
        checks++; if (period_cnt !== exp_pc) begin errors++; $display("FAIL stop_period_cnt: got %h want %h", period_cnt, exp_pc); end
        repeat (3) step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stop_stay_idle: got %b want 0", busy); end
    endtask

    task automatic test_reset_in_load();
        start = 1'b1;
        step();
        checks++; if (load_n !== 1'b0 || preset !== 8'hFE) begin errors++; $display("FAIL rl_setup: load_n=%b preset=%h want 0 fe", load_n, preset); end
        pin_name1 = 1'b1;
        step();
        exp_pc = '0;
        checks++; if (load_n !== 1'b1) begin errors++; $display("FAIL rl_load_n: got %b want 1", load_n); end
        checks++; if (preset !== 8'h8F) begin errors++; $display("FAIL rl_preset: got %h want 8f", preset); end
        checks++; if (div_tick !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rl_tick_busy: got %b %b want 0 0", div_tick, busy); end
        checks++; if (period_cnt !== 16'd0) begin errors++; $display("FAIL rl_period_cnt: got %h want 0", period_cnt); end
        start = 1'b0;
        pin_name1 = 1'b0;
        step();
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL rl_cfg_ready: got %b want 1", cfg_ready); end
        start = 1'b1;
        step();
        start = 1'b0;
        checks++; if (preset !== 8'h8F) begin errors++; $display("FAIL rl_shadow_reset: got %h want 8f", preset); end
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    task automatic test_saturation();
        logic [31:0] l;
        force dut.u_period.count_q = 16'hFFFD;
        step();
        release dut.u_period.count_q;
        exp_pc = 16'hFFFD;
        step();
        checks++; if (period_cnt !== 16'hFFFD) begin errors++; $display("FAIL sat_setup: got %h want fffd", period_cnt); end
        mode = 1'b0;
        cfg_valid = 1'b1;
        cfg_data = 8'hFF;
        start = 1'b1;
        step();
        l = cyc;
        cfg_valid = 1'b0;
        start = 1'b0;
        for (int k = 1; k <= 5; k++) push_tick(l + 32'(2 * k));
        for (int i = 0; i <= 10; i++) begin
            checks++;
            if (load_n !== ((i % 2 == 0) ? 1'b0 : 1'b1)) begin
                errors++;
                $display("FAIL sat_load_alt: cyc=%0d got %b want %b", cyc, load_n, (i % 2 == 0) ? 1'b0 : 1'b1);
            end
            if (i < 10) step();
        end
        checks++; if (exp_tick_q.size() != 0) begin errors++; $display("FAIL sat_timeout: %0d ticks missing, want 0", exp_tick_q.size()); end
        checks++; if (period_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_hold: got %h want ffff", period_cnt); end
        stop = 1'b1;
        step();
        stop = 1'b0;
        exp_tick_q.delete();
        exp_pc_q.delete();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_continuous();
        test_cfg_midrun();
        test_one_shot();
        test_stop_at_terminal();
        test_reset_in_load();
        test_saturation();
        repeat (3) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/divider_sequencer.md
DIVIDER_SEQUENCER -- requirements
Module: divider_sequencer

Interface
REQ-001 Parameter TERMINAL, default 8'hFF, counter value that ends a period.
REQ-002 Parameter DEFAULT_PRESET, default 8'h8F, preset after reset.
REQ-003 clock_oscillator  in  1  single clock; all state changes on its rising edge.
REQ-004 pin_name1  in  1  reset; synchronous and active-high.
REQ-005 start  in  1  level, sampled each cycle; begins sequencing from IDLE.
REQ-006 stop  in  1  level; aborts sequencing, returns to IDLE.
REQ-007 mode  in  1  0 = continuous reload, 1 = one-shot (single period).
REQ-008 cfg_valid  in  1  new preset offered.
REQ-009 cfg_data  in  8  offered preset value.
REQ-010 cfg_ready  out  1  preset can be accepted this cycle.
REQ-011 cnt_q  in  8  live output of the 8-bit loadable counter.
REQ-012 load_n  out  1  counter load strobe, active-low; the counter loads synchronously.
REQ-013 preset  out  8  value presented to the counter parallel inputs.
REQ-014 div_tick  out  1  one-cycle pulse per completed period.
REQ-015 busy  out  1  high in LOAD and RUN.
REQ-016 period_cnt  out  16  completed periods since reset, saturating.

Function
REQ-017 FSM states: IDLE, LOAD, RUN. All outputs registered or decoded from state only.
REQ-018 IDLE: on start=1 and stop=0, go to LOAD. Otherwise stay.
REQ-019 LOAD lasts exactly one cycle: load_n=0, preset stable. Next state is RUN; IDLE if stop=1.
REQ-020 RUN: when cnt_q==TERMINAL, the next state is LOAD if mode=0, IDLE if mode=1.
REQ-021 Terminal detect in RUN asserts div_tick for the following cycle and increments period_cnt.
- The increment saturates at 16'hFFFF.
REQ-022 cnt_q is ignored outside RUN; the stale value during LOAD never produces a tick.
REQ-023 Period timing: with preset P, consecutive LOAD cycles are 257-P cycles apart.
- P=TERMINAL gives 2 cycles, which is legal.
REQ-024 Handshake: cfg_ready=1 in IDLE and RUN, 0 in LOAD.
- A transfer occurs when cfg_valid&cfg_ready.
- The accepted value goes to a shadow register.
REQ-025 The shadow is copied to preset on entry to LOAD; preset never changes while in RUN.
REQ-026 A transfer in the same cycle as terminal detect applies to that reload.
REQ-027 A second transfer before the next LOAD overwrites the shadow; last value wins.
REQ-028 stop=1 has priority over start and over terminal detect: next state is IDLE, no tick, no increment.
REQ-029 mode is sampled at terminal detect only. Changing mode mid-period takes effect at that period's end.
REQ-030 load_n=1 in every state except LOAD.

Reset
REQ-031 pin_name1=1 at a clock edge sets the following, regardless of current state, including mid-LOAD:
- state=IDLE, load_n=1
- preset=DEFAULT_PRESET, shadow=DEFAULT_PRESET
- div_tick=0, period_cnt=0, busy=0
REQ-032 cfg_ready=1 in the first cycle after reset is released.
REQ-033 Inputs are ignored while pin_name1=1.

Structure
REQ-034 A shared package holds the following, imported by the sequencer and its bench:
- FSM state typedef
- TERMINAL and DEFAULT_PRESET constants
- counter width (8) and period_cnt width (16)
REQ-035 One sub-module, sat_counter16, implements the saturating period counter.
REQ-036 The bench includes a behavioural 8-bit up-counter with synchronous active-low load, connected to load_n, preset and cnt_q.

Verification
REQ-037 Reset, then start=1 with default preset 8'h8F, mode=0 -> load_n low for 1 cycle; div_tick every 114 cycles; period_cnt=3 after the third tick.
REQ-038 cfg_data=8'hF0 accepted mid-RUN -> current period unchanged; following periods are 17 cycles.
REQ-039 mode=1, preset 8'hFE -> exactly one div_tick 3 cycles after LOAD, then IDLE with busy=0 and load_n=1.
REQ-040 stop=1 in the same cycle cnt_q==8'hFF -> no div_tick, period_cnt unchanged, IDLE next cycle.
REQ-041 pin_name1 pulsed during LOAD -> load_n=1 and preset=8'h8F next cycle; no tick.
REQ-042 Preset 8'hFF, continuous, period_cnt forced near 16'hFFFF -> 2-cycle period, load_n alternating; period_cnt holds at 16'hFFFF.
